// File: rtl/ysyx_24110015_axi_pkg.sv
// Shared types and constants for the AXI-lite initiator.
// State encoding plus response codes used when classifying rresp/bresp.
package ysyx_24110015_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_WR   = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Anything but OKAY, including EXOKAY, is reported to the core as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite signal bundle shared by the initiator and the responders.
// Master drives address/data/valids and response readies; slave the rest.
interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/ysyx_24110015_Reg.sv
// Generic register with write enable and asynchronous active-high reset.
// One-cycle update latency; holds its value whenever wen is low.
module ysyx_24110015_Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end
endmodule

// File: rtl/ysyx_24110015_axi_lite_master.sv
// Converts one outstanding core load/store into an AXI-lite read or write.
// Min 4 cycles per request; req_ready only in IDLE, rsp_valid is a 1-cycle pulse.
module ysyx_24110015_axi_lite_master
    import ysyx_24110015_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_wmask,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    axi_lite_if.master        axi
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wmask_q;
    logic              wen_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q, err_d;
    logic              aw_done_q, w_done_q;

    logic req_fire;
    logic aw_hs, w_hs;
    logic r_fire, b_fire;

    assign req_fire = (state_q == ST_IDLE) && req_valid;
    assign aw_hs    = (state_q == ST_WR) && !aw_done_q && axi.awready;
    assign w_hs     = (state_q == ST_WR) && !w_done_q && axi.wready;
    assign r_fire   = (state_q == ST_R) && axi.rvalid;
    assign b_fire   = (state_q == ST_B) && axi.bvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_valid) state_d = req_wen ? ST_WR : ST_AR;
            ST_AR:   if (axi.arready) state_d = ST_R;
            ST_R:    if (axi.rvalid) state_d = ST_DONE;
            // Leave as soon as the later of the two handshakes lands, even same-cycle.
            ST_WR:   if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_B;
            ST_B:    if (axi.bvalid) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_d = resp_is_err(axi.bresp);
        if (state_q == ST_R) begin
            err_d = resp_is_err(axi.rresp);
        end
    end

    ysyx_24110015_Reg #(.WIDTH(ADDR_W)) u_addr_reg (
        .clk(clk), .rst(rst), .din(req_addr), .dout(addr_q), .wen(req_fire)
    );

    ysyx_24110015_Reg #(.WIDTH(DATA_W)) u_wdata_reg (
        .clk(clk), .rst(rst), .din(req_wdata), .dout(wdata_q), .wen(req_fire)
    );

    ysyx_24110015_Reg #(.WIDTH(4)) u_wmask_reg (
        .clk(clk), .rst(rst), .din(req_wmask), .dout(wmask_q), .wen(req_fire)
    );

    ysyx_24110015_Reg #(.WIDTH(1)) u_wen_reg (
        .clk(clk), .rst(rst), .din(req_wen), .dout(wen_q), .wen(req_fire)
    );

    ysyx_24110015_Reg #(.WIDTH(DATA_W)) u_rdata_reg (
        .clk(clk), .rst(rst), .din(axi.rdata), .dout(rdata_q), .wen(r_fire)
    );

    ysyx_24110015_Reg #(.WIDTH(1)) u_err_reg (
        .clk(clk), .rst(rst), .din(err_d), .dout(err_q), .wen(r_fire || b_fire)
    );

    // Done flags clear on acceptance and set on their own handshake; the two are exclusive.
    ysyx_24110015_Reg #(.WIDTH(1)) u_aw_done_reg (
        .clk(clk), .rst(rst), .din(aw_hs), .dout(aw_done_q), .wen(req_fire || aw_hs)
    );

    ysyx_24110015_Reg #(.WIDTH(1)) u_w_done_reg (
        .clk(clk), .rst(rst), .din(w_hs), .dout(w_done_q), .wen(req_fire || w_hs)
    );

    assign req_ready   = (state_q == ST_IDLE);

    assign axi.araddr  = addr_q;
    assign axi.arvalid = (state_q == ST_AR);
    assign axi.rready  = (state_q == ST_R);

    assign axi.awaddr  = addr_q;
    assign axi.awvalid = (state_q == ST_WR) && !aw_done_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wmask_q;
    assign axi.wvalid  = (state_q == ST_WR) && !w_done_q;
    assign axi.bready  = (state_q == ST_B);

    // rdata_q may still hold an earlier read, so writes report zero explicitly.
    assign rsp_valid   = (state_q == ST_DONE);
    assign rsp_rdata   = (state_q == ST_DONE && !wen_q) ? rdata_q : '0;
    assign rsp_err     = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_ysyx_24110015_axi_lite_master.sv
// Bench for the AXI-lite initiator: configurable-latency responder, response scoreboard,
// vector table for the common cases and hand-written reset / held-request sequences.
module tb_ysyx_24110015_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ysyx_24110015_axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .axi(bus)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Responder configuration: cycles each ready/valid is held off after the partner asserts.
    int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic [31:0] r_data = '0;
    logic [1:0]  r_resp = 2'b00, b_resp = 2'b00;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;

    always @(negedge clk) begin
        if (bus.arvalid) begin bus.arready = (ar_cnt >= ar_wait); ar_cnt++; end
        else begin bus.arready = 1'b0; ar_cnt = 0; end
        if (bus.awvalid) begin bus.awready = (aw_cnt >= aw_wait); aw_cnt++; end
        else begin bus.awready = 1'b0; aw_cnt = 0; end
        if (bus.wvalid) begin bus.wready = (w_cnt >= w_wait); w_cnt++; end
        else begin bus.wready = 1'b0; w_cnt = 0; end
        if (bus.rready) begin bus.rvalid = (r_cnt >= r_wait); r_cnt++; end
        else begin bus.rvalid = 1'b0; r_cnt = 0; end
        if (bus.bready) begin bus.bvalid = (b_cnt >= b_wait); b_cnt++; end
        else begin bus.bvalid = 1'b0; b_cnt = 0; end
        bus.rdata = r_data;
        bus.rresp = r_resp;
        bus.bresp = b_resp;
    end

    int ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0;
    always @(posedge clk) begin
        if (bus.arvalid && bus.arready) ar_hs++;
        if (bus.awvalid && bus.awready) aw_hs++;
        if (bus.wvalid && bus.wready)   w_hs++;
        if (bus.rvalid && bus.rready)   r_hs++;
        if (bus.bvalid && bus.bready)   b_hs++;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] cur_addr = '0, cur_wdata = '0;
    logic [3:0]  cur_wmask = '0;
    int ar_vc = 0, aw_vc = 0, w_vc = 0;

    // Bus stability and response scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.arvalid) begin
                ar_vc++;
                check("araddr_stable", bus.araddr, cur_addr);
            end
            if (bus.awvalid) begin
                aw_vc++;
                check("awaddr_stable", bus.awaddr, cur_addr);
            end
            if (bus.wvalid) begin
                w_vc++;
                check("wdata_stable", bus.wdata, cur_wdata);
                check("wstrb_stable", {28'd0, bus.wstrb}, {28'd0, cur_wmask});
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 want 0 (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
        end
    end

    typedef struct {
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          ar_w, r_w, aw_w, w_w, b_w;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    task automatic run_txn(input vec_t v, input bit hold);
        int lat;
        int exp_lat;
        int aw_max;
        bit seen;
        ar_wait = v.ar_w; r_wait = v.r_w; aw_wait = v.aw_w; w_wait = v.w_w; b_wait = v.b_w;
        r_data = v.rdata; r_resp = v.resp; b_resp = v.resp;
        aw_max = (v.aw_w > v.w_w) ? v.aw_w : v.w_w;
        exp_lat = v.wen ? (3 + aw_max + v.b_w) : (3 + v.ar_w + v.r_w);
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        ar_vc = 0; aw_vc = 0; w_vc = 0;
        ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0;
        req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr;
        req_wdata = v.wdata; req_wmask = v.wmask;
        cur_addr = v.addr; cur_wdata = v.wdata; cur_wmask = v.wmask;
        exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        seen = 1'b0;
        lat = 0;
        for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check("arvalid_c1", {31'd0, bus.arvalid}, {31'd0, !v.wen});
                check("awvalid_c1", {31'd0, bus.awvalid}, {31'd0, v.wen});
                check("wvalid_c1", {31'd0, bus.wvalid}, {31'd0, v.wen});
            end
            if (rsp_valid) begin
                seen = 1'b1;
                lat = cyc;
                req_valid = 1'b0;
            end else begin
                check("req_ready_busy", {31'd0, req_ready}, 32'd0);
                if (hold) begin
                    req_addr = $urandom;
                    req_wdata = $urandom;
                    req_wen = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: got no rsp_valid want one within 60 cycles");
            exp_q.delete();
        end else begin
            check("latency", lat, exp_lat);
        end
        @(negedge clk);
        check("rsp_single_pulse", {31'd0, rsp_valid}, 32'd0);
        check("req_ready_after", {31'd0, req_ready}, 32'd1);
        if (v.wen) begin
            check("aw_hs_count", aw_hs, 1);
            check("w_hs_count", w_hs, 1);
            check("b_hs_count", b_hs, 1);
            check("ar_hs_none", ar_hs, 0);
            check("awvalid_cycles", aw_vc, 1 + v.aw_w);
            check("wvalid_cycles", w_vc, 1 + v.w_w);
        end else begin
            check("ar_hs_count", ar_hs, 1);
            check("r_hs_count", r_hs, 1);
            check("aw_hs_none", aw_hs, 0);
            check("arvalid_cycles", ar_vc, 1 + v.ar_w);
        end
    endtask

    vec_t vecs[9];

    initial begin
        //         wen   addr          wdata         wmask    ar r aw w b  rdata         resp   exp_rdata     err
        vecs[0] = '{1'b0, 32'h0200_0000, 32'h0,        4'b0000, 0, 0, 0, 0, 0, 32'h0000_1234, 2'b00, 32'h0000_1234, 1'b0};
        vecs[1] = '{1'b0, 32'h0F00_0004, 32'h0,        4'b0000, 3, 2, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h8000_0010, 32'hA5A5_A5A5, 4'b0011, 0, 0, 2, 0, 0, 32'h1111_1111, 2'b00, 32'h0,        1'b0};
        vecs[3] = '{1'b1, 32'h8000_0010, 32'hA5A5_A5A5, 4'b0011, 0, 0, 0, 2, 0, 32'h1111_1111, 2'b00, 32'h0,        1'b0};
        vecs[4] = '{1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'b1111, 0, 0, 0, 0, 1, 32'h2222_2222, 2'b10, 32'h0,        1'b1};
        vecs[5] = '{1'b0, 32'h1000_0000, 32'h0,        4'b0000, 0, 1, 0, 0, 0, 32'hCAFE_F00D, 2'b11, 32'hCAFE_F00D, 1'b1};
        vecs[6] = '{1'b0, 32'h8000_0040, 32'h0,        4'b0000, 1, 0, 0, 0, 0, 32'h1111_2222, 2'b00, 32'h1111_2222, 1'b0};
        vecs[7] = '{1'b1, 32'h8000_0044, 32'h1357_9BDF, 4'b1100, 0, 0, 1, 1, 0, 32'h0,        2'b01, 32'h0,        1'b1};
        vecs[8] = '{1'b1, 32'h8000_0048, 32'h0246_8ACE, 4'b1000, 0, 0, 1, 3, 2, 32'h0,        2'b00, 32'h0,        1'b0};

        #1 rst = 1'b1;
        #3;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp", {rsp_rdata[30:0], rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_valids", {27'd0, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 32'd0);
        check("rst_araddr", bus.araddr, 32'd0);
        check("rst_wdata", bus.wdata | bus.awaddr | {28'd0, bus.wstrb}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i], 1'b0);
        end

        // Reset while waiting in R with rready asserted.
        ar_wait = 0; r_wait = 6; r_data = 32'h7777_7777; r_resp = 2'b00;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h3000_0000; cur_addr = 32'h3000_0000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.rready; i++) @(negedge clk);
        @(negedge clk);
        check("in_r_before_rst", {31'd0, bus.rready}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valids", {27'd0, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_araddr", bus.araddr, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("post_rst_no_pending", exp_q.size(), 0);

        // req_valid held high with a wandering address while busy.
        run_txn('{1'b0, 32'h0200_0008, 32'h0, 4'b0000, 1, 1, 0, 0, 0,
                  32'h0000_ABCD, 2'b00, 32'h0000_ABCD, 1'b0}, 1'b1);
        run_txn('{1'b1, 32'h8000_0100, 32'hFEED_FACE, 4'b0101, 0, 0, 0, 0, 0,
                  32'h0, 2'b00, 32'h0, 1'b0}, 1'b0);

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
